// File: rtl/ssp_tx_logic_if.sv
// rtl/ssp_tx_logic_if.sv - TxFIFO pop handshake and SSP transmit pad signals
interface ssp_tx_logic_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] TxDATA;
    logic              TxVALID;
    logic              TxREAD;
    logic              SSPTXD;
    logic              SSPFSSOUT;
    logic              SSPCLKOUT;
    logic              SSPOE_B;
    logic              BUSY;

    // master: the transmit logic itself
    modport master (
        input  TxDATA,
        input  TxVALID,
        output TxREAD,
        output SSPTXD,
        output SSPFSSOUT,
        output SSPCLKOUT,
        output SSPOE_B,
        output BUSY
    );

    // slave: the TxFIFO / pad ring side
    modport slave (
        output TxDATA,
        output TxVALID,
        input  TxREAD,
        input  SSPTXD,
        input  SSPFSSOUT,
        input  SSPCLKOUT,
        input  SSPOE_B,
        input  BUSY
    );
endinterface

// File: rtl/ssp_tx_logic.sv
// rtl/ssp_tx_logic.sv - SSP TI-frame transmitter; SSP_TX_CONTINUOUS_EN enables back-to-back chaining
module ssp_tx_logic #(
    parameter int DATA_W   = 8,
    parameter int HALF_PER = 1
) (
    input  logic           PCLK,
    input  logic           CLEAR,
    ssp_tx_logic_if.master bus
);
    localparam int BW = $clog2(DATA_W);
    localparam int CW = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_nxt;
    logic [CW-1:0]     tick_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              clk_q;
    logic              fss_q;
    logic              txd_q;
    logic              oe_b_q;
    logic              read_q;
    logic              hold_vld;

    logic tick;
    logic fall;
    logic start;
    logic sync_fall;
    logic shift_fall;
    logic chain_pop;
    logic chain_load;
    logic term;

    assign tick = (state_q != IDLE) && (tick_cnt == CW'(HALF_PER - 1));
    assign fall = tick && clk_q;

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (bus.TxVALID) state_nxt = SYNC;
            SYNC:    if (fall) state_nxt = SHIFT;
            SHIFT:   if (fall && (bit_cnt == '0) && !hold_vld) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control strobes; at most one of start/sync_fall/shift_fall/chain_load/term per edge,
    // chain_pop only ever accompanies the shift_fall that drives bit 0.
    always_comb begin
        start      = 1'b0;
        sync_fall  = 1'b0;
        shift_fall = 1'b0;
        chain_pop  = 1'b0;
        chain_load = 1'b0;
        term       = 1'b0;
        case (state_q)
            IDLE: start = bus.TxVALID;
            SYNC: sync_fall = fall;
            SHIFT: begin
                if (fall) begin
                    if (bit_cnt != '0) begin
                        shift_fall = 1'b1;
`ifdef SSP_TX_CONTINUOUS_EN
                        chain_pop  = (bit_cnt == BW'(1)) && bus.TxVALID;
`endif
                    end else if (hold_vld) begin
                        chain_load = 1'b1;
                    end else begin
                        term = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef SSP_TX_CONTINUOUS_EN
    logic [DATA_W-1:0] hold;

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            hold     <= '0;
            hold_vld <= 1'b0;
        end else if (chain_pop) begin
            hold     <= bus.TxDATA;
            hold_vld <= 1'b1;
        end else if (chain_load) begin
            hold_vld <= 1'b0;
        end
    end
`else
    logic [DATA_W-1:0] hold;

    assign hold     = '0;
    assign hold_vld = 1'b0;
`endif

    // Half-period timing and the serial clock itself
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            tick_cnt <= '0;
            clk_q    <= 1'b0;
        end else if (state_q == IDLE || term) begin
            tick_cnt <= '0;
            clk_q    <= 1'b0;
        end else if (tick) begin
            tick_cnt <= '0;
            clk_q    <= ~clk_q;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            shreg   <= '0;
            bit_cnt <= '0;
            txd_q   <= 1'b0;
        end else if (start) begin
            shreg <= bus.TxDATA;
        end else if (sync_fall || shift_fall) begin
            txd_q   <= shreg[DATA_W-1];
            shreg   <= shreg << 1;
            bit_cnt <= sync_fall ? BW'(DATA_W - 1) : bit_cnt - BW'(1);
        end else if (chain_load) begin
            txd_q   <= hold[DATA_W-1];
            shreg   <= hold << 1;
            bit_cnt <= BW'(DATA_W - 1);
        end else if (term) begin
            txd_q   <= 1'b0;
            bit_cnt <= '0;
        end
    end

    // Frame sync covers the SYNC period, or bit 0 of a word that has a successor queued
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            fss_q  <= 1'b0;
            oe_b_q <= 1'b1;
            read_q <= 1'b0;
        end else begin
            read_q <= start || chain_pop;
            if (start || chain_pop) begin
                fss_q <= 1'b1;
            end else if (sync_fall || chain_load || term) begin
                fss_q <= 1'b0;
            end
            if (start) begin
                oe_b_q <= 1'b0;
            end else if (term) begin
                oe_b_q <= 1'b1;
            end
        end
    end

    assign bus.TxREAD    = read_q;
    assign bus.SSPTXD    = txd_q;
    assign bus.SSPFSSOUT = fss_q;
    assign bus.SSPCLKOUT = clk_q;
    assign bus.SSPOE_B   = oe_b_q;
    assign bus.BUSY      = (state_q != IDLE);
endmodule

// File: tb/tb_ssp_tx_logic.sv
// tb/tb_ssp_tx_logic.sv - directed bench for ssp_tx_logic (8-bit/HALF_PER=1 and 16-bit/HALF_PER=3 instances)
module tb_ssp_tx_logic;
    logic PCLK  = 1'b0;
    logic CLEAR = 1'b1;

    always #5 PCLK = ~PCLK;

    ssp_tx_logic_if #(.DATA_W(8))  bus0();
    ssp_tx_logic_if #(.DATA_W(16)) bus1();

    ssp_tx_logic #(.DATA_W(8),  .HALF_PER(1)) u0 (.PCLK(PCLK), .CLEAR(CLEAR), .bus(bus0));
    ssp_tx_logic #(.DATA_W(16), .HALF_PER(3)) u1 (.PCLK(PCLK), .CLEAR(CLEAR), .bus(bus1));

`ifdef SSP_TX_CONTINUOUS_EN
    localparam int PAIR_BUSY = 34, PAIR_GAP = 0, PAIR_DT = 16, PAIR_FSSD = 1;
    localparam int TRIO_BUSY = 50, TRIO_GAP = 0;
`else
    localparam int PAIR_BUSY = 36, PAIR_GAP = 1, PAIR_DT = 19, PAIR_FSSD = 0;
    localparam int TRIO_BUSY = 54, TRIO_GAP = 2;
`endif

    typedef struct {
        bit       tv;
        bit [5:0] exp;   // {clk, fss, txd, oe_b, rd, busy}
    } vec_t;

    vec_t     vt[19];
    int       n_cmp = 0;
    int       n_bad = 0;
    bit [7:0] fifo_q[$];
    int       rx_q[$];
    int       read_at[$];
    int       busy_cyc, gap_cyc, fss_data;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int obs0();
        return int'({bus0.SSPCLKOUT, bus0.SSPFSSOUT, bus0.SSPTXD, bus0.SSPOE_B, bus0.TxREAD, bus0.BUSY});
    endfunction

    function automatic int rx_at(input int i);
        return (rx_q.size() > i) ? rx_q[i] : -1;
    endfunction

    task automatic set_in();
        bus0.TxVALID = (fifo_q.size() != 0);
        bus0.TxDATA  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    // FIFO model feeding u0 plus a receive-side model sampling on SSPCLKOUT rises
    task automatic run_stream(input int budget);
        int cyc = 0, cnt = 0, first_b = -1, last_b = -1;
        bit prev_clk = 1'b0, act = 1'b0, was_data, done = 1'b0;
        logic [7:0] sr = 8'h00;
        rx_q.delete();
        read_at.delete();
        busy_cyc = 0;
        fss_data = 0;
        set_in();
        while (!done && cyc < budget) begin
            @(negedge PCLK);
            cyc++;
            if (bus0.TxREAD) begin
                read_at.push_back(cyc);
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
                set_in();
            end
            if (bus0.BUSY) begin
                busy_cyc++;
                if (first_b < 0) first_b = cyc;
                last_b = cyc;
            end
            if (bus0.SSPCLKOUT && !prev_clk) begin
                was_data = act;
                if (act) begin
                    sr = {sr[6:0], bus0.SSPTXD};
                    cnt++;
                    if (cnt == 8) begin
                        rx_q.push_back(int'(sr));
                        act = 1'b0;
                    end
                end
                if (bus0.SSPFSSOUT) begin
                    if (was_data) fss_data++;
                    act = 1'b1;
                    cnt = 0;
                end
            end
            prev_clk = bus0.SSPCLKOUT;
            if (first_b >= 0 && !bus0.BUSY && fifo_q.size() == 0) done = 1'b1;
        end
        if (!done) chk("stream_timeout", cyc, -1);
        gap_cyc = (first_b < 0) ? -1 : (last_b - first_b + 1 - busy_cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, first_hi, txd_hi, b_cyc, bits, c;
        bit prev_clk, seen;
        logic [15:0] sr16;

        vt[0]  = '{1'b1, 6'b010011};
        vt[1]  = '{1'b0, 6'b110001};
        vt[2]  = '{1'b0, 6'b001001};
        vt[3]  = '{1'b0, 6'b101001};
        vt[4]  = '{1'b0, 6'b000001};
        vt[5]  = '{1'b0, 6'b100001};
        vt[6]  = '{1'b0, 6'b001001};
        vt[7]  = '{1'b0, 6'b101001};
        vt[8]  = '{1'b0, 6'b000001};
        vt[9]  = '{1'b0, 6'b100001};
        vt[10] = '{1'b0, 6'b000001};
        vt[11] = '{1'b0, 6'b100001};
        vt[12] = '{1'b0, 6'b001001};
        vt[13] = '{1'b0, 6'b101001};
        vt[14] = '{1'b0, 6'b000001};
        vt[15] = '{1'b0, 6'b100001};
        vt[16] = '{1'b0, 6'b001001};
        vt[17] = '{1'b0, 6'b101001};
        vt[18] = '{1'b0, 6'b000100};

        bus0.TxVALID = 1'b0;
        bus0.TxDATA  = 8'h00;
        bus1.TxVALID = 1'b0;
        bus1.TxDATA  = 16'h0000;
        repeat (3) @(negedge PCLK);
        chk("reset_u0", obs0(), 6'b000100);
        chk("reset_u1", int'({bus1.SSPCLKOUT, bus1.SSPFSSOUT, bus1.SSPTXD, bus1.SSPOE_B, bus1.TxREAD, bus1.BUSY}), 6'b000100);
        CLEAR = 1'b0;
        @(negedge PCLK);

        // Single 0xA5 frame, cycle by cycle
        bus0.TxDATA = 8'hA5;
        for (int i = 0; i < 19; i++) begin
            bus0.TxVALID = vt[i].tv;
            @(negedge PCLK);
            chk($sformatf("a5_k%0d", i), obs0(), int'(vt[i].exp));
        end
        @(negedge PCLK);

        // Pair 0x3C, 0xC3
        fifo_q = '{8'h3C, 8'hC3};
        run_stream(200);
        chk("pair_nrx", rx_q.size(), 2);
        chk("pair_w0", rx_at(0), 8'h3C);
        chk("pair_w1", rx_at(1), 8'hC3);
        chk("pair_nreads", read_at.size(), 2);
        chk("pair_first_read", (read_at.size() > 0) ? read_at[0] : -1, 1);
        chk("pair_read_dt", (read_at.size() > 1) ? read_at[1] - read_at[0] : -1, PAIR_DT);
        chk("pair_busy", busy_cyc, PAIR_BUSY);
        chk("pair_gap", gap_cyc, PAIR_GAP);
        chk("pair_fss_bit0", fss_data, PAIR_FSSD);
        @(negedge PCLK);

        // Loopback of 0x00, 0xFF, 0x5A
        fifo_q = '{8'h00, 8'hFF, 8'h5A};
        run_stream(300);
        chk("trio_nrx", rx_q.size(), 3);
        chk("trio_w0", rx_at(0), 8'h00);
        chk("trio_w1", rx_at(1), 8'hFF);
        chk("trio_w2", rx_at(2), 8'h5A);
        chk("trio_busy", busy_cyc, TRIO_BUSY);
        chk("trio_gap", gap_cyc, TRIO_GAP);
        @(negedge PCLK);

        // CLEAR during bit 4 of 0xFF
        fifo_q = '{8'hFF};
        set_in();
        for (c = 1; c <= 9; c++) begin
            @(negedge PCLK);
            if (bus0.TxREAD) begin
                void'(fifo_q.pop_front());
                set_in();
            end
        end
        chk("clr_pre", int'({bus0.SSPCLKOUT, bus0.SSPTXD, bus0.BUSY}), 3'b011);
        #2 CLEAR = 1'b1;
        #1 chk("clr_async", obs0(), 6'b000100);
        repeat (2) @(negedge PCLK);
        CLEAR = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge PCLK);
            if (bus0.BUSY || bus0.TxREAD || !bus0.SSPOE_B) bad++;
        end
        chk("clr_stays_idle", bad, 0);

        // 16-bit word 0x8001 at HALF_PER=3
        bus1.TxDATA  = 16'h8001;
        bus1.TxVALID = 1'b1;
        first_hi = -1; txd_hi = 0; b_cyc = 0; bits = 0; sr16 = '0;
        prev_clk = 1'b0; seen = 1'b0;
        c = 0;
        while (c < 200 && !(seen && !bus1.BUSY)) begin
            @(negedge PCLK);
            c++;
            if (bus1.TxREAD) bus1.TxVALID = 1'b0;
            if (bus1.BUSY) begin
                b_cyc++;
                seen = 1'b1;
            end
            if (bus1.SSPTXD) begin
                txd_hi++;
                if (first_hi < 0) first_hi = c;
            end
            if (bus1.SSPCLKOUT && !prev_clk && !bus1.SSPFSSOUT) begin
                sr16 = {sr16[14:0], bus1.SSPTXD};
                bits++;
            end
            prev_clk = bus1.SSPCLKOUT;
        end
        chk("hp3_done", int'(seen && !bus1.BUSY), 1);
        chk("hp3_busy", b_cyc, 102);
        chk("hp3_first_msb", first_hi, 7);
        chk("hp3_txd_hi", txd_hi, 12);
        chk("hp3_bits", bits, 16);
        chk("hp3_word", int'(sr16), 16'h8001);
        chk("hp3_oe_idle", int'(bus1.SSPOE_B), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
